branch_resolver: RTL
====================

// Module: branch_resolver
// PURPOSE
//  Execute-stage consumer of the fetch-side always-taken branch prediction. Evaluates each
//  resolved branch's condition against live PSW flags. On mispredict: redirects fetch to the
//  saved fall-through PC, restores the saved PSW, and squashes younger stages.
//  Sits between the execute stage and the fetch PC mux / stage-register flush inputs.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush[] held high after a mispredict (fetch+decode depth)
//  STAT_W        16  width of the statistics counters (BR_STATS_EN only)
// PORTS
//  clk               in   1   pipeline clock, rising edge
//  rst               in   1   asynchronous, active-high reset
//  ex_valid          in   1   execute stage holds a valid instruction
//  ex_is_branch      in   1   instruction is a conditional branch (opcode msbs 3'b001)
//  ex_cond           in   3   branch condition field, cond_e encoding
//  psw_flags         in   4   live flags {V,N,Z,C}
//  lbpc              in   16  saved fall-through PC (predicted-branch PC + 2)
//  lbpsw             in   16  saved PSW for rollback
//  redirect_valid    out  1   one-cycle pulse: load redirect_pc into fetch PC
//  redirect_pc       out  16  corrected PC
//  psw_restore_valid out  1   one-cycle pulse: load psw_restore into PSW
//  psw_restore       out  16  PSW rollback value
//  flush             out  1   squash fetch/decode stage registers and stage_3/4 dependency memory
//  busy              out  1   high while in SQUASH; execute results must not commit
//  br_count          out  STAT_W  resolved branches (BR_STATS_EN)
//  mp_count          out  STAT_W  mispredicts (BR_STATS_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Reset mid-SQUASH aborts the squash immediately.
//  - Condition taken (cond_e):
//      0 EQ: Z    1 NE: !Z   2 CS: C    3 CC: !C
//      4 MI: N    5 GE: N==V 6 LT: N!=V 7 AL: 1
//  - Fetch always predicts taken, so mispredict = ex_valid & ex_is_branch & !taken, sampled in IDLE only.
//  - Cycle N, mispredict detected:
//      * N+1: registered redirect_valid=1, redirect_pc=lbpc, psw_restore_valid=1,
//        psw_restore=lbpsw, flush=1, busy=1, state=SQUASH, cnt=FLUSH_CYCLES-1.
//      * Pulses last exactly one cycle.
//      * flush/busy stay high through N+FLUSH_CYCLES, then state returns to IDLE.
//  - SQUASH: ex_* inputs ignored (wrong-path). No new redirect; counters not incremented.
//  - lbpc/lbpsw are captured at detection. Later input changes do not alter a pulse in flight.
//  - Correct prediction, or non-branch: no output activity; state stays IDLE.
//  - Back-to-back mispredicts: the second one arrives during SQUASH and is dropped by definition
//    (it is on the wrong path).
//  - FLUSH_CYCLES=1: SQUASH lasts one cycle; IDLE from N+2.
// CONFIGURATION
//  - BR_STATS_EN defined: br_count increments on every branch resolved in IDLE; mp_count
//    increments on each mispredict. Both saturate at all-ones.
//  - BR_STATS_EN undefined: ports kept, tied to 0, no counter flops.
// STRUCTURE
//  - Package xm23_branch_pkg: cond_e enum (3 bit), br_state_e {IDLE,SQUASH},
//    PSW bit index constants (PSW_C=0, PSW_Z=1, PSW_N=2, PSW_V=4).
//  - Sub-module branch_cond_eval: combinational (cond, flags) -> taken. Shared with the
//    future conditional-execution unit.
// TESTING
//  1 Reset: assert rst mid-run -> all outputs 0 in the same cycle. Deassert -> IDLE, counters 0.
//  2 EQ branch, Z=1, lbpc=16'h0104 -> no redirect, no flush, br_count=1, mp_count=0.
//  3 NE branch, Z=1, lbpc=16'h0200, lbpsw=16'h0003 -> N+1: redirect_pc=0200, psw_restore=0003,
//    pulses 1 cycle. flush high N+1..N+2.
//  4 Mispredict followed next cycle by a mispredicting branch (GE, N=1,V=0) -> single redirect,
//    mp_count=1.
//  5 AL branch with any flags -> never redirects. LT with N=0,V=1 -> taken, no redirect.
//  6 BR_STATS_EN, STAT_W=4: 20 mispredicts -> mp_count saturates at 4'hF.
//    Without the macro: counters stay 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the xm23 branch resolution logic.
// Latency: n/a (types only).
// Backpressure: n/a.
//   cond_e     : 3-bit branch condition encoding
//   br_state_e : resolver FSM states
//   PSW_*      : bit positions in the 16-bit PSW register
//   FLG_*      : bit positions in the 4-bit live flag vector {V,N,Z,C}
package xm23_branch_pkg;

  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_CS = 3'd2,
    COND_CC = 3'd3,
    COND_MI = 3'd4,
    COND_GE = 3'd5,
    COND_LT = 3'd6,
    COND_AL = 3'd7
  } cond_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } br_state_e;

  // PSW register layout (bit 3 is not a flag in the PSW).
  localparam int PSW_C = 0;
  localparam int PSW_Z = 1;
  localparam int PSW_N = 2;
  localparam int PSW_V = 4;

  // The flag bus is packed densely, so V sits at bit 3 here, not bit 4.
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: (cond, flags) -> taken.
// Latency: purely combinational.
// Backpressure: none.
//   cond  in  3  condition field, cond_e encoding
//   flags in  4  live flags {V,N,Z,C}
//   taken out 1  condition holds
module branch_cond_eval
  import xm23_branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic f_c, f_z, f_n, f_v;

  assign f_c = flags[FLG_C];
  assign f_z = flags[FLG_Z];
  assign f_n = flags[FLG_N];
  assign f_v = flags[FLG_V];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = f_z;
      COND_NE: taken = !f_z;
      COND_CS: taken = f_c;
      COND_CC: taken = !f_c;
      COND_MI: taken = f_n;
      COND_GE: taken = (f_n == f_v);
      COND_LT: taken = (f_n != f_v);
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves always-taken predictions at execute; on mispredict redirects fetch, restores PSW, squashes.
// Latency: redirect/restore pulses and flush appear one cycle after detection; flush held FLUSH_CYCLES.
// Backpressure: none; while busy the ex_* inputs are wrong-path and ignored.
//   Ports: clk, rst (async, active high), ex_valid/ex_is_branch/ex_cond, psw_flags {V,N,Z,C},
//          lbpc/lbpsw (rollback state), redirect_valid/redirect_pc, psw_restore_valid/psw_restore,
//          flush, busy, br_count/mp_count.
//   Optional statistics counters enabled by defining BR_STATS_EN; otherwise counts read 0.
module branch_resolver
  import xm23_branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [2:0]        ex_cond,
  input  logic [3:0]        psw_flags,
  input  logic [15:0]       lbpc,
  input  logic [15:0]       lbpsw,
  output logic              redirect_valid,
  output logic [15:0]       redirect_pc,
  output logic              psw_restore_valid,
  output logic [15:0]       psw_restore,
  output logic              flush,
  output logic              busy,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mp_count
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             taken;
  logic             mispredict;
  logic             pulse_q;
  logic [15:0]      pc_q;
  logic [15:0]      psw_q;

  branch_cond_eval u_cond (
    .cond  (ex_cond),
    .flags (psw_flags),
    .taken (taken)
  );

  // Fetch always predicts taken, so any not-taken branch is a mispredict.
  // Only looked at in IDLE: during SQUASH the execute stage holds wrong-path work.
  assign mispredict = (state == IDLE) && ex_valid && ex_is_branch && !taken;

  // State register plus the captured rollback payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
      pc_q    <= '0;
      psw_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= mispredict;
      // Capture at detection so later input changes cannot alter the pulse.
      if (mispredict) begin
        pc_q  <= lbpc;
        psw_q <= lbpsw;
      end
    end
  end

  // Next-state logic: cnt counts the remaining SQUASH cycles after the first.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_nxt = SQUASH;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      SQUASH: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: all derived from flops, so they clear with reset in the same cycle.
  always_comb begin
    redirect_valid    = pulse_q;
    redirect_pc       = pc_q;
    psw_restore_valid = pulse_q;
    psw_restore       = psw_q;
    flush             = (state == SQUASH);
    busy              = (state == SQUASH);
  end

`ifdef BR_STATS_EN
  logic              resolve;
  logic [STAT_W-1:0] br_q, mp_q;

  assign resolve = (state == IDLE) && ex_valid && ex_is_branch;

  // Saturating counters: stop at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (resolve && (br_q != '1))    br_q <= br_q + STAT_W'(1);
      if (mispredict && (mp_q != '1)) mp_q <= mp_q + STAT_W'(1);
    end
  end

  assign br_count = br_q;
  assign mp_count = mp_q;
`else
  assign br_count = {STAT_W{1'b0}};
  assign mp_count = {STAT_W{1'b0}};
`endif

endmodule
